// File: rtl/ppu_update_sched.sv
// ppu_update_sched: arbitrates two update requesters into a FIFO and streams entries or board clears to the PPU during vblank
module ppu_update_sched #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic        vblank,
    input  logic        a_valid,
    input  logic [16:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [16:0] b_data,
    output logic        b_ready,
    input  logic        clr_req,
    input  logic        clr_board,
    output logic        clr_busy,
    output logic        receive,
    output logic        board,
    output logic [6:0]  square_update,
    output logic [1:0]  square_state,
    output logic [1:0]  ship_type,
    output logic [2:0]  ship_section,
    output logic        vert,
    output logic        square_sel,
    output logic [4:0]  fifo_level,
    output logic        drop_err
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t        state, state_nx;
    logic [16:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [4:0]    level;
    logic          last_b, clr_b, recv_q, drop_q;
    logic [6:0]    cnt;
    logic [16:0]   out_q, win, out_nx;
    logic          idle, full, empty, acc, push, can_pop, pop, bypass, wr, clr_issue;

    assign idle      = state == IDLE;
    assign full      = level == DEPTH;
    assign empty     = level == 5'd0;
    assign a_ready   = idle && !full && a_valid && (!b_valid || last_b);
    assign b_ready   = idle && !full && b_valid && !a_ready;
    assign acc       = a_ready || b_ready;
    assign win       = a_ready ? a_data : b_data;
    assign push      = acc && win[15:9] < 7'd100;
    assign can_pop   = vblank && state != CLEAR;
    assign pop       = can_pop && !empty;
    // an empty FIFO hands the accepted word straight through so it reaches the PPU one cycle later
    assign bypass    = can_pop && empty && push;
    assign wr        = push && !bypass;
    assign clr_issue = state == CLEAR && vblank;
    assign clr_busy  = !idle;
    assign fifo_level = level;
    assign drop_err  = drop_q;
    assign receive   = recv_q;
    assign {board, square_update, square_state, ship_type, ship_section, vert, square_sel} = out_q;

    // next state and next PPU word
    always_comb begin
        state_nx = idle && clr_req ? DRAIN
                 : state == DRAIN && empty ? CLEAR
                 : clr_issue && cnt == 7'd99 ? IDLE
                 : state;
        out_nx = (pop || bypass) ? (empty ? win : mem[rd_ptr])
               : clr_issue ? {clr_b, cnt, 9'd0}
               : 17'd0;
    end

    // FIFO storage, no reset needed since pointers define validity
    always_ff @(posedge vga_clk) begin
        if (wr) mem[wr_ptr] <= win;
    end

    // control state, FIFO pointers, clear counter and registered PPU outputs
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= 5'd0;
            last_b <= 1'b1;
            clr_b  <= 1'b0;
            cnt    <= 7'd0;
            recv_q <= 1'b0;
            drop_q <= 1'b0;
            out_q  <= 17'd0;
        end else begin
            state  <= state_nx;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
            level  <= level + 5'(wr) - 5'(pop);
            last_b <= a_ready ? 1'b0 : b_ready ? 1'b1 : last_b;
            clr_b  <= idle && clr_req ? clr_board : clr_b;
            cnt    <= clr_issue ? (cnt == 7'd99 ? 7'd0 : cnt + 7'd1) : cnt;
            recv_q <= pop || bypass || clr_issue;
            drop_q <= acc && !push;
            out_q  <= out_nx;
        end
    end
endmodule

// File: tb/tb_ppu_update_sched.sv
// tb_ppu_update_sched: directed self-checking bench for ppu_update_sched
module tb_ppu_update_sched;
    logic        vga_clk = 0, rst_n = 0, vblank = 0;
    logic        a_valid = 0, b_valid = 0, clr_req = 0, clr_board = 0;
    logic [16:0] a_data = 0, b_data = 0;
    logic        a_ready, b_ready, clr_busy, receive, board, vert, square_sel, drop_err;
    logic [6:0]  square_update;
    logic [1:0]  square_state, ship_type;
    logic [2:0]  ship_section;
    logic [4:0]  fifo_level;
    logic [16:0] word;
    logic [16:0] exp_q [4];
    logic [16:0] got [$];
    logic        vb;
    int          checks = 0, failures = 0;
    int          late, ready_bad, bad, n, busy;
    logic        done, found;

    ppu_update_sched #(.FIFO_DEPTH(4)) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .vblank(vblank),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .clr_req(clr_req), .clr_board(clr_board), .clr_busy(clr_busy),
        .receive(receive), .board(board), .square_update(square_update),
        .square_state(square_state), .ship_type(ship_type), .ship_section(ship_section),
        .vert(vert), .square_sel(square_sel), .fifo_level(fifo_level), .drop_err(drop_err)
    );

    assign word = {board, square_update, square_state, ship_type, ship_section, vert, square_sel};

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic step;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 0; vblank = 0; a_valid = 0; b_valid = 0; clr_req = 0; clr_board = 0;
        step;
        step;
        rst_n = 1;
    endtask

    initial begin
        step;
        check("rst_receive", receive, 0);
        check("rst_word", word, 0);
        check("rst_busy", clr_busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_drop", drop_err, 0);
        rst_n = 1;
        step;

        vblank = 1; a_valid = 1; a_data = 17'h0C8E3;
        #1 check("drop_ready", a_ready, 1);
        step;
        a_valid = 0;
        check("drop_err", drop_err, 1);
        check("drop_recv", receive, 0);
        check("drop_level", fifo_level, 0);
        step;
        check("drop_pulse_end", drop_err, 0);
        check("drop_no_recv", receive, 0);

        vblank = 0; a_valid = 1; a_data = {1'b0, 7'd99, 9'h0AA};
        step;
        a_valid = 0;
        check("sq99_no_drop", drop_err, 0);
        check("sq99_level", fifo_level, 1);
        check("sq99_vb0_no_recv", receive, 0);
        vblank = 1;
        step;
        check("sq99_recv", receive, 1);
        check("sq99_word", word, 17'h0C6AA);
        check("sq99_level0", fifo_level, 0);

        do_reset;
        vblank = 0; a_valid = 1; b_valid = 1;
        for (int i = 0; i < 4; i++) begin
            a_data = {1'b0, 7'(10 + i), 9'h000};
            b_data = {1'b1, 7'(20 + i), 9'h1FF};
            exp_q[i] = (i % 2 == 0) ? a_data : b_data;
            #1;
            check("alt_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
            check("alt_b_ready", b_ready, (i % 2 == 1) ? 1 : 0);
            step;
        end
        check("full_a_ready", a_ready, 0);
        check("full_b_ready", b_ready, 0);
        check("full_level", fifo_level, 4);
        check("full_no_recv", receive, 0);
        a_valid = 0; b_valid = 0; vblank = 1;
        for (int i = 0; i < 4; i++) begin
            step;
            check("order_recv", receive, 1);
            check("order_word", word, exp_q[i]);
        end
        step;
        check("order_done", receive, 0);
        check("order_level", fifo_level, 0);

        a_valid = 1; a_data = 17'h155C6;
        step;
        a_valid = 0;
        check("single_recv", receive, 1);
        check("single_word", word, 17'h155C6);
        check("single_board", board, 1);
        check("single_square", square_update, 42);
        check("single_state", square_state, 3);
        check("single_type", ship_type, 2);
        check("single_section", ship_section, 1);
        check("single_vert", vert, 1);
        check("single_sel", square_sel, 0);
        step;
        check("single_after_recv", receive, 0);
        check("single_after_zero", word, 0);

        vblank = 0; a_valid = 1;
        for (int i = 0; i < 3; i++) begin
            a_data = {1'b0, 7'(5 + i), 9'h003};
            step;
        end
        a_valid = 0;
        check("clr_pre_level", fifo_level, 3);
        got.delete();
        late = 0; ready_bad = 0; done = 0;
        for (int c = 0; c < 500 && !done; c++) begin
            vblank = ((c / 10) % 2 == 0);
            clr_req = (c == 0);
            clr_board = (c == 0);
            a_valid = (c != 0);
            b_valid = (c != 0);
            a_data = {1'b0, 7'd77, 9'h000};
            b_data = {1'b1, 7'd78, 9'h000};
            #1;
            if (c != 0 && (a_ready || b_ready)) ready_bad++;
            vb = vblank;
            step;
            if (receive) begin
                got.push_back(word);
                if (!vb) late++;
            end
            if (!clr_busy) done = 1;
        end
        a_valid = 0; b_valid = 0; clr_req = 0;
        check("clr_done", done, 1);
        check("clr_count", got.size(), 103);
        check("clr_late", late, 0);
        check("clr_ready", ready_bad, 0);
        bad = 0;
        if (got.size() == 103) begin
            for (int i = 0; i < 3; i++)
                check("clr_drain_word", got[i], {1'b0, 7'(5 + i), 9'h003});
            for (int i = 0; i < 100; i++)
                if (got[i + 3] !== {1'b1, 7'(i), 9'h000}) bad++;
        end else bad = -1;
        check("clr_words", bad, 0);

        vblank = 1; clr_req = 1; clr_board = 0;
        step;
        clr_req = 0;
        found = 0;
        for (int c = 0; c < 300 && !found; c++) begin
            step;
            if (receive && square_update == 7'd50) found = 1;
        end
        check("rst50_found", found, 1);
        check("rst50_word", word, {1'b0, 7'd50, 9'h000});
        rst_n = 0;
        #1;
        check("rst50_recv", receive, 0);
        check("rst50_zero", word, 0);
        check("rst50_busy_now", clr_busy, 0);
        check("rst50_level", fifo_level, 0);
        step;
        step;
        rst_n = 1;
        n = 0; busy = 0;
        repeat (150) begin
            step;
            if (receive) n++;
            if (clr_busy) busy++;
        end
        check("rst50_no_recv", n, 0);
        check("rst50_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
